// File: rtl/elevator_call_scheduler.sv
// Call-button front end plus SCAN (collective) scheduler: debounced presses become
// latched requests, served floor by floor with mutually exclusive up/down requests.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS      = 8,
    parameter int FLOOR_W         = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MOVE_CYCLES     = 16,
    parameter int DOOR_CYCLES     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    output logic                  up_button,
    output logic                  down_button,
    output logic                  door_hold,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  arrived
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int MOVE_W = $clog2(MOVE_CYCLES);
    localparam int DOOR_W = $clog2(DOOR_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    // ------------------------------------------------------------------
    // Floor-indexed helpers; any floor outside 0..NUM_FLOORS-1 reads as 0.
    // ------------------------------------------------------------------
    function automatic logic req_at(input logic [NUM_FLOORS-1:0] req,
                                    input logic [FLOOR_W-1:0]    floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i == int'(floor)) hit = hit | req[i];
        end
        return hit;
    endfunction

    function automatic logic req_above(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]    floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(floor)) hit = hit | req[i];
        end
        return hit;
    endfunction

    function automatic logic req_below(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]    floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(floor)) hit = hit | req[i];
        end
        return hit;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] floor);
        logic [NUM_FLOORS-1:0] mask;
        mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i == int'(floor)) mask[i] = 1'b1;
        end
        return mask;
    endfunction

    // ------------------------------------------------------------------
    // Input path: 2-FF synchroniser, per-bit debouncer, rising-edge detect
    // ------------------------------------------------------------------
    logic [NUM_FLOORS-1:0] sync_meta;
    logic [NUM_FLOORS-1:0] sync_q;
    logic [NUM_FLOORS-1:0] deb_q;
    logic [NUM_FLOORS-1:0] deb_prev;
    logic [NUM_FLOORS-1:0] rise;
    logic [DEB_W-1:0]      deb_cnt [NUM_FLOORS];

    // NOTE: the counter array is only a few flops per button, so it is reset
    // explicitly; a button held through reset must restart its debounce cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            deb_q     <= '0;
            deb_prev  <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) deb_cnt[i] <= '0;
        end else begin
            sync_meta <= call_btn;
            sync_q    <= sync_meta;
            deb_prev  <= deb_q;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (sync_q[i] == deb_q[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_q[i]   <= sync_q[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = deb_q & ~deb_prev;

    // ------------------------------------------------------------------
    // Position-relative views of the pending requests
    // ------------------------------------------------------------------
    state_t                state;
    dir_t                  last_dir;
    logic [MOVE_W-1:0]     travel_cnt;
    logic [DOOR_W-1:0]     door_cnt;

    logic [FLOOR_W-1:0]    up_floor;
    logic [FLOOR_W-1:0]    down_floor;
    logic [NUM_FLOORS-1:0] cur_mask;
    logic [NUM_FLOORS-1:0] up_mask;
    logic [NUM_FLOORS-1:0] down_mask;
    logic                  here;
    logic                  above;
    logic                  below;
    logic                  press_here;
    logic                  up_hit;
    logic                  up_beyond;
    logic                  down_hit;
    logic                  down_beyond;

    always_comb begin
        up_floor    = cur_floor + 1'b1;
        down_floor  = cur_floor - 1'b1;
        cur_mask    = floor_mask(cur_floor);
        up_mask     = floor_mask(up_floor);
        down_mask   = floor_mask(down_floor);
        here        = req_at(pending, cur_floor);
        above       = req_above(pending, cur_floor);
        below       = req_below(pending, cur_floor);
        press_here  = |(rise & cur_mask);
        up_hit      = req_at(pending, up_floor);
        up_beyond   = req_above(pending, up_floor);
        down_hit    = req_at(pending, down_floor);
        down_beyond = req_below(pending, down_floor);
    end

    // ------------------------------------------------------------------
    // SCAN scheduler; outputs are registered alongside every state change
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_dir    <= DIR_UP;
            cur_floor   <= '0;
            pending     <= '0;
            travel_cnt  <= '0;
            door_cnt    <= '0;
            up_button   <= 1'b0;
            down_button <= 1'b0;
            door_hold   <= 1'b0;
            arrived     <= 1'b0;
        end else begin
            // NOTE: a later <= to the same register in this block overrides this
            // default, which is how a service clear beats a same-cycle press.
            pending    <= pending | rise;
            arrived    <= 1'b0;
            travel_cnt <= '0;
            door_cnt   <= '0;

            unique case (state)
                IDLE: begin
                    if (here) begin
                        state       <= DOOR;
                        door_hold   <= 1'b1;
                        pending     <= (pending | rise) & ~cur_mask;
                        arrived     <= 1'b1;
                    end else if (above) begin
                        state       <= MOVE_UP;
                        up_button   <= 1'b1;
                        last_dir    <= DIR_UP;
                    end else if (below) begin
                        state       <= MOVE_DOWN;
                        down_button <= 1'b1;
                        last_dir    <= DIR_DOWN;
                    end
                end

                MOVE_UP: begin
                    if (travel_cnt != MOVE_LAST) begin
                        travel_cnt <= travel_cnt + 1'b1;
                    end else begin
                        cur_floor <= up_floor;
                        if (up_hit) begin
                            state     <= DOOR;
                            up_button <= 1'b0;
                            door_hold <= 1'b1;
                            pending   <= (pending | rise) & ~up_mask;
                            arrived   <= 1'b1;
                        end else if (!up_beyond) begin
                            state     <= IDLE;
                            up_button <= 1'b0;
                        end
                    end
                end

                MOVE_DOWN: begin
                    if (travel_cnt != MOVE_LAST) begin
                        travel_cnt <= travel_cnt + 1'b1;
                    end else begin
                        cur_floor <= down_floor;
                        if (down_hit) begin
                            state       <= DOOR;
                            down_button <= 1'b0;
                            door_hold   <= 1'b1;
                            pending     <= (pending | rise) & ~down_mask;
                            arrived     <= 1'b1;
                        end else if (!down_beyond) begin
                            state       <= IDLE;
                            down_button <= 1'b0;
                        end
                    end
                end

                DOOR: begin
                    // A fresh press at the open floor is absorbed and re-arms the door.
                    if (here || press_here) begin
                        pending <= (pending | rise) & ~cur_mask;
                    end else if (door_cnt != DOOR_LAST) begin
                        door_cnt <= door_cnt + 1'b1;
                    end else begin
                        door_hold <= 1'b0;
                        if (last_dir == DIR_UP) begin
                            if (above) begin
                                state       <= MOVE_UP;
                                up_button   <= 1'b1;
                            end else if (below) begin
                                state       <= MOVE_DOWN;
                                down_button <= 1'b1;
                                last_dir    <= DIR_DOWN;
                            end else begin
                                state       <= IDLE;
                            end
                        end else begin
                            if (below) begin
                                state       <= MOVE_DOWN;
                                down_button <= 1'b1;
                            end else if (above) begin
                                state       <= MOVE_UP;
                                up_button   <= 1'b1;
                                last_dir    <= DIR_UP;
                            end else begin
                                state       <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    up_button   <= 1'b0;
                    down_button <= 1'b0;
                    door_hold   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Design invariants
    // ------------------------------------------------------------------
    a_dir_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(up_button && down_button));

    a_floor_range: assert property (@(posedge clk) disable iff (reset)
        int'(cur_floor) < NUM_FLOORS);

    a_up_headroom: assert property (@(posedge clk) disable iff (reset)
        (state == MOVE_UP) |-> (int'(cur_floor) < NUM_FLOORS - 1));

    a_down_headroom: assert property (@(posedge clk) disable iff (reset)
        (state == MOVE_DOWN) |-> (cur_floor != '0));

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Upstream request stage for the elevator control FSM. It synchronises and debounces the raw per-floor call buttons and latches them as pending requests. It tracks the cabin position with a per-floor travel timer and runs a SCAN (collective) policy. Its outputs are the mutually exclusive up_button/down_button levels consumed by the control FSM, plus door-hold and position status.

Parameters:
NUM_FLOORS, 8, number of served floors (2..16); floors are 0..NUM_FLOORS-1
FLOOR_W, 4, width of floor index outputs
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required to accept a button level change (>=2)
MOVE_CYCLES, 16, clock cycles to travel one floor (>=2)
DOOR_CYCLES, 8, clock cycles the door is held at a served floor (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
call_btn  input  NUM_FLOORS  raw asynchronous call buttons, bit i = floor i, active-high
up_button  output  1  request upward motion to control FSM, registered
down_button  output  1  request downward motion to control FSM, registered
door_hold  output  1  high while the door is held open at a served floor, registered
cur_floor  output  FLOOR_W  current cabin floor index
pending  output  NUM_FLOORS  latched outstanding requests
arrived  output  1  one-cycle pulse when a request is served

Behaviour:
- Reset, asynchronous: state=IDLE, cur_floor=0, pending=0, all outputs 0, sync/debounce/travel/door counters=0, last_dir=UP. Reset mid-motion abandons travel; no homing.
- Input path, per bit: 2-FF synchroniser, then debouncer. A counter increments while sync != debounced and clears when they are equal. When count==DEBOUNCE_CYCLES-1 and the values still differ, debounced<=sync and the count clears.
- Registered rising-edge detect on debounced sets pending[i]. A clean press is visible on pending[i] exactly 2+DEBOUNCE_CYCLES+1 cycles after call_btn[i] rises. Glitches shorter than DEBOUNCE_CYCLES are ignored. Holding a button produces one request only.
- Set/clear collision on the same bit in the same cycle: clear wins, because the floor is being served.
- Definitions: above = |pending[NUM_FLOORS-1:cur_floor+1]|; below = |pending[cur_floor-1:0]|; here = pending[cur_floor]. Out-of-range slices evaluate to 0.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- Outputs are registered from next state: up_button=(state==MOVE_UP), down_button=(state==MOVE_DOWN), door_hold=(state==DOOR). up_button and down_button are never high together.
- IDLE decision, priority order:
  - here: go to DOOR, clear the bit, pulse arrived.
  - else above: go to MOVE_UP, last_dir=UP.
  - else below: go to MOVE_DOWN, last_dir=DOWN.
  - else stay in IDLE.
  - Transition takes effect on the next edge after the condition is seen.
- MOVE_UP / MOVE_DOWN:
  - travel_cnt increments each cycle. On the edge where travel_cnt==MOVE_CYCLES-1: cur_floor moves ±1 and travel_cnt clears.
  - Same edge, evaluated for the new floor: if pending[new] then go to DOOR, clear it, pulse arrived.
  - Else if requests remain beyond the new floor in the current direction, continue.
  - Else go to IDLE.
  - cur_floor never exceeds NUM_FLOORS-1 or drops below 0; the beyond-check guarantees this, and any violation is a design error to assert.
- DOOR:
  - door_cnt counts to DOOR_CYCLES-1.
  - If pending[cur_floor] sets during DOOR: clear it, restart door_cnt, no extra arrived pulse.
  - On expiry: continue in last_dir if requests exist beyond; else reverse if requests exist opposite; else go to IDLE.
- Requests at the current floor while moving are ignored until the next floor-arrival evaluation.
- arrived is high for exactly one cycle per service event.

Test Plan:
- Reset then call_btn[3] pulse held 10 cycles -> pending=8'h08 at cycle 2+4+1; up_button=1 next cycle; cur_floor 1,2,3 at 16-cycle intervals; at floor 3 up_button=0, door_hold=1 for 8 cycles, arrived one pulse, pending=0, then IDLE.
- call_btn[0] pressed while IDLE at floor 0 -> no motion, door_hold=1 for 8 cycles, arrived pulse, pending cleared.
- At floor 2 moving up with pending floors 5 and 1 -> stops at 5, door expires, reverses, down_button=1, stops at 1, then IDLE.
- 2-cycle glitch on call_btn[6] -> pending stays 0, no motion.
- call_btn[4] pressed again during DOOR at floor 4 -> door_cnt restarts, door_hold lasts 8 cycles from the re-press acceptance, single arrived pulse only.
- Assert reset mid-travel between floors 2 and 3 -> all outputs 0, cur_floor=0, pending=0 asynchronously; a fresh call to floor 1 is then served normally.
